acc_mem_responder: RTL

Memory-side responder for the accelerator read/write request protocol: it services the initiator's read_enable/finish_read and write_enable/finish_write handshakes from an internal 64-bit word array after a fixed, parameterised latency. It sits between an accelerator wrapper and the platform, or in the bench. A host port loads inputs and fetches results. Only one accelerator request is outstanding at a time; each beat completes with a one-cycle ready pulse.

---
 rtl/acc_mem_responder.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/acc_mem_responder.sv
// acc_mem_responder
//
// Memory-side responder for the accelerator read/write request protocol. Read and
// write beats are served from an internal 64-bit word array after LATENCY cycles.
// Each completed beat produces a one-cycle ready pulse. Only one accelerator
// request is outstanding at a time. A host port loads inputs and fetches results.
//
// Parameters:
//   DEPTH    number of 64-bit words (power of two); AW = log2(DEPTH)
//   LATENCY  cycles from request acceptance to the ready pulse (>= 1)
//
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   read_enable_i/read_addr_i      read burst active / byte address of the current beat
//   read_size_i                    beat size in bytes (must be 8)
//   finish_read_i                  previous beat consumed, read_addr_i holds the next beat
//   read_ready_o/read_data_o       bit 0 = one-cycle data-valid pulse / beat data
//   write_enable_i/write_addr_i    write burst active / byte address of the current beat
//   write_size_i/write_data_i      beat size in bytes (must be 8) / beat data
//   finish_write_i                 next write beat's addr/data are valid
//   write_ready_o                  bit 0 = one-cycle write-committed pulse
//   host_we_i/host_addr_i          host write strobe / host word index
//   host_wdata_i/host_rdata_o      host write data / registered read of mem[host_addr_i]
//   err_o                          sticky protocol error flag
//
// Optional feature (macro ACC_MEM_RESP_STATS_EN):
//   rd_beats_o/wr_beats_o          32-bit beat counters, frozen while err_o is set

module acc_mem_responder #(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 2,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          read_enable_i,
    input  logic [63:0]   read_addr_i,
    input  logic [63:0]   read_size_i,
    input  logic          finish_read_i,
    output logic [63:0]   read_ready_o,
    output logic [63:0]   read_data_o,
    input  logic          write_enable_i,
    input  logic [63:0]   write_addr_i,
    input  logic [63:0]   write_size_i,
    input  logic [63:0]   write_data_i,
    input  logic          finish_write_i,
    output logic [63:0]   write_ready_o,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [63:0]   host_wdata_i,
    output logic [63:0]   host_rdata_o,
    output logic          err_o
`ifdef ACC_MEM_RESP_STATS_EN
    ,
    output logic [31:0]   rd_beats_o,
    output logic [31:0]   wr_beats_o
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_LAT  = 3'd1;
    localparam logic [2:0] RD_DONE = 3'd2;
    localparam logic [2:0] WR_LAT  = 3'd3;
    localparam logic [2:0] WR_DONE = 3'd4;

    // With LATENCY == 1 the beat completes on the acceptance edge itself.
    localparam bit          Immediate = (LATENCY == 1);
    localparam int unsigned CntW      = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int unsigned LastCnt   = (LATENCY >= 2) ? LATENCY - 2 : 0;
    localparam logic [CntW-1:0] LastCntW = CntW'(LastCnt);

    logic [63:0] mem [DEPTH];

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            rd_ready_q, wr_ready_q;
    logic [63:0]     rd_data_q;
    logic [63:0]     host_rdata_q;
    logic            err_q;

    logic            rd_accept, wr_accept;
    logic            rd_fire, wr_fire;
    logic [AW-1:0]   fire_idx;
    logic [63:0]     fire_wdata;
    logic            err_set;

    logic [AW-1:0]   rd_idx_in, wr_idx_in;
    assign rd_idx_in = read_addr_i[3 +: AW];
    assign wr_idx_in = write_addr_i[3 +: AW];

    // Upper address bits are intentionally ignored (index wraps modulo DEPTH).
    logic unused_addr;
    assign unused_addr = ^{read_addr_i[63:3+AW], write_addr_i[63:3+AW]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rd_accept  = 1'b0;
        wr_accept  = 1'b0;
        rd_fire    = 1'b0;
        wr_fire    = 1'b0;
        fire_idx   = idx_q;
        fire_wdata = wdata_q;
        err_set    = 1'b0;

        case (state_q)
            IDLE: begin
                if (read_enable_i) begin
                    rd_accept = 1'b1;
                end else if (write_enable_i) begin
                    wr_accept = 1'b1;
                end
            end
            RD_LAT: begin
                if (cnt_q == LastCntW) begin
                    rd_fire = 1'b1;
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RD_DONE: begin
                if (finish_read_i) begin
                    rd_accept = 1'b1;
                end else if (!read_enable_i) begin
                    state_d = IDLE;
                end
            end
            WR_LAT: begin
                if (cnt_q == LastCntW) begin
                    wr_fire = 1'b1;
                    state_d = WR_DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            WR_DONE: begin
                if (finish_write_i) begin
                    wr_accept = 1'b1;
                end else if (!write_enable_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_accept) begin
            idx_d = rd_idx_in;
            cnt_d = '0;
            if (read_addr_i[2:0] != 3'b000 || read_size_i != 64'd8) begin
                err_set = 1'b1;
            end
            if (Immediate) begin
                rd_fire  = 1'b1;
                fire_idx = rd_idx_in;
                state_d  = RD_DONE;
            end else begin
                state_d = RD_LAT;
            end
        end

        if (wr_accept) begin
            idx_d   = wr_idx_in;
            wdata_d = write_data_i;
            cnt_d   = '0;
            if (write_addr_i[2:0] != 3'b000 || write_size_i != 64'd8) begin
                err_set = 1'b1;
            end
            if (Immediate) begin
                wr_fire    = 1'b1;
                fire_idx   = wr_idx_in;
                fire_wdata = write_data_i;
                state_d    = WR_DONE;
            end else begin
                state_d = WR_LAT;
            end
        end

        // A finish pulse is only legal while the matching beat is parked in DONE.
        if (finish_read_i && state_q != RD_DONE) begin
            err_set = 1'b1;
        end
        if (finish_write_i && state_q != WR_DONE) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            rd_ready_q   <= 1'b0;
            wr_ready_q   <= 1'b0;
            rd_data_q    <= '0;
            host_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            rd_ready_q   <= rd_fire;
            wr_ready_q   <= wr_fire;
            if (rd_fire) begin
                rd_data_q <= mem[fire_idx];
            end
            host_rdata_q <= mem[host_addr_i];
            err_q        <= err_q | err_set;
        end
    end

    // Storage is not reset. The accelerator write is issued last so it wins a
    // same-edge collision with the host; the reset gate keeps an aborted beat
    // from committing.
    always_ff @(posedge clk_i) begin
        if (host_we_i) begin
            mem[host_addr_i] <= host_wdata_i;
        end
        if (wr_fire && !reset_i) begin
            mem[fire_idx] <= fire_wdata;
        end
    end

`ifdef ACC_MEM_RESP_STATS_EN
    logic [31:0] rd_beats_q, wr_beats_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_beats_q <= '0;
            wr_beats_q <= '0;
        end else if (!err_q) begin
            if (rd_fire) begin
                rd_beats_q <= rd_beats_q + 32'd1;
            end
            if (wr_fire) begin
                wr_beats_q <= wr_beats_q + 32'd1;
            end
        end
    end

    assign rd_beats_o = rd_beats_q;
    assign wr_beats_o = wr_beats_q;
`endif

    assign read_ready_o  = {63'b0, rd_ready_q};
    assign write_ready_o = {63'b0, wr_ready_q};
    assign read_data_o   = rd_data_q;
    assign host_rdata_o  = host_rdata_q;
    assign err_o         = err_q;

endmodule
